// File: rtl/spi_lcd_rx_pkg.sv
// Shared types and constants for the SPI LCD-link receiver.
// Latency: n/a (declarations and elaboration-time helpers only).
// Backpressure: n/a.
package spi_lcd_rx_pkg;

  localparam int BYTE_W  = 8;
  localparam int ENTRY_W = BYTE_W + 1;  // {dc, byte}

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Idle-SCK timeout in clock cycles. The product is formed before the
  // divide so that slow clocks (e.g. 120 kHz) do not truncate to zero.
  function automatic int calc_timeout_cycles(input longint clk_freq, input longint timeout_us);
    longint cycles;
    cycles = (clk_freq * timeout_us) / 1_000_000;
    if (cycles < 1) cycles = 1;
    return int'(cycles);
  endfunction

  // Timer width, sized so the counter can hold the terminal count itself.
  function automatic int calc_timer_w(input longint clk_freq, input longint timeout_us);
    return $clog2(calc_timeout_cycles(clk_freq, timeout_us) + 1);
  endfunction

endpackage

// File: rtl/spi_lcd_rx_if.sv
// Bundle of SPI pins, received-byte handshake and status flags.
// Latency: n/a (wires only).
// Backpressure: rx_valid/rx_ready; slave = receiver, master = link driver/consumer.
interface spi_lcd_rx_if;

  logic                              spi_sck;
  logic                              spi_mosi;
  logic                              spi_cs_n;
  logic                              spi_dc;
  logic                              spi_miso;
  logic [spi_lcd_rx_pkg::BYTE_W-1:0] rx_data;
  logic                              rx_dc;
  logic                              rx_valid;
  logic                              rx_ready;
  logic                              frame_start;
  logic                              err_overflow;
  logic                              err_partial;
  logic                              err_clr;

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n, spi_dc, rx_ready, err_clr,
    output spi_miso, rx_data, rx_dc, rx_valid, frame_start, err_overflow, err_partial
  );

  modport master (
    output spi_sck, spi_mosi, spi_cs_n, spi_dc, rx_ready, err_clr,
    input  spi_miso, rx_data, rx_dc, rx_valid, frame_start, err_overflow, err_partial
  );

endinterface

// File: rtl/spi_lcd_rx_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// Latency: a write is visible at the head on the cycle after it is accepted.
// Backpressure: write refused when full unless a read frees a slot that same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             rd_rdy_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             rd_en, wr_en;

  // Extra MSB on each pointer tells a full ring from an empty one.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_en   = rd_rdy_i && !empty_o;
  assign wr_en   = wr_vld_i && (!full_o || rd_en);

  // Head reads as zero when empty so the outputs are clean out of reset.
  assign rd_dat_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  // Pointer advance; both wrap naturally through the extra bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_dat_i;
  end

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI mode-0 responder for the LCD link: bytes tagged with DC into a FWFT FIFO.
// Latency: push on the synchronized 8th SCK rise, rx_valid the next cycle (<=4 clk from the pin).
// Backpressure: rx_valid/rx_ready; a byte completing while full is dropped (err_overflow).
// Optional MISO echo of the previous byte is built only when SPI_LCD_RX_MISO_EN is defined.
module spi_lcd_rx
  import spi_lcd_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int TIMEOUT_US = 100,
  parameter int FIFO_DEPTH = 16
) (
  input logic         clk_12mhz,
  input logic         rst_n,
  spi_lcd_rx_if.slave bus
);

  localparam int TIMEOUT_CYCLES = calc_timeout_cycles(CLK_FREQ, TIMEOUT_US);
  localparam int TIMER_W        = calc_timer_w(CLK_FREQ, TIMEOUT_US);
  localparam int BIT_CNT_W      = $clog2(BYTE_W);

  // ---------------------------------------------------------------------
  // Input synchronizers: [0],[1] = 2-flop sync, [2] = edge-detect history.
  // ---------------------------------------------------------------------
  logic [2:0] sck_q, mosi_q, cs_q, dc_q;
  logic       sck_rise, cs_low, cs_fall, mosi_s, dc_s;

  // Bring the asynchronous SPI pins into the clk_12mhz domain.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= 3'b000;
      mosi_q <= 3'b000;
      cs_q   <= 3'b111;
      dc_q   <= 3'b000;
    end else begin
      sck_q  <= {sck_q[1:0],  bus.spi_sck};
      mosi_q <= {mosi_q[1:0], bus.spi_mosi};
      cs_q   <= {cs_q[1:0],   bus.spi_cs_n};
      dc_q   <= {dc_q[1:0],   bus.spi_dc};
    end
  end

  // Data/DC are taken from the stage one older than the SCK edge detect,
  // which gives a clock of setup margin against the rising edge.
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_low   = ~cs_q[1];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign mosi_s   = mosi_q[2];
  assign dc_s     = dc_q[2];

  // ---------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BYTE_W-2:0]      shift_q;
  logic [TIMER_W-1:0]     timer_q;
  logic                   timeout_hit, byte_last;
  logic                   frame_start_d, push, part_set, shift_en, timer_clr, timer_inc;
  logic [BYTE_W-1:0]      byte_dat;
  logic                   frame_start_q, err_ovf_q, err_part_q;
  logic                   fifo_full, fifo_empty, ovf_set;
  logic [ENTRY_W-1:0]     fifo_rd_dat;

  assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT_CYCLES));
  assign byte_last   = (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
  assign byte_dat    = {shift_q, mosi_s};

  // State register.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: CS_N high always wins; an SCK edge beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (!cs_low) state_d = IDLE;
               else if (!sck_rise && timeout_hit) state_d = HOLD;
      HOLD:    if (!cs_low) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath, FIFO and flags.
  always_comb begin
    frame_start_d = 1'b0;
    push          = 1'b0;
    part_set      = 1'b0;
    shift_en      = 1'b0;
    timer_clr     = 1'b0;
    timer_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          frame_start_d = 1'b1;
          timer_clr     = 1'b1;
        end
      end
      SHIFT: begin
        if (!cs_low) begin
          part_set = (bit_cnt_q != '0);
        end else if (sck_rise) begin
          shift_en  = 1'b1;
          timer_clr = 1'b1;
          push      = byte_last;
        end else if (timeout_hit) begin
          part_set = (bit_cnt_q != '0);
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bit counter, deserializer and idle-SCK timer.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      timer_q   <= '0;
    end else begin
      if (frame_start_d)  bit_cnt_q <= '0;
      else if (shift_en)  bit_cnt_q <= byte_last ? '0 : bit_cnt_q + 1'b1;
      if (shift_en)       shift_q   <= {shift_q[BYTE_W-3:0], mosi_s};
      if (timer_clr)      timer_q   <= '0;
      else if (timer_inc) timer_q   <= timer_q + 1'b1;
    end
  end

  // A completed byte is lost only if no pop frees a slot in the same cycle.
  assign ovf_set = push && fifo_full && !bus.rx_ready;

  // Frame-start pulse and sticky error flags; a new error beats err_clr.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_part_q    <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      err_ovf_q     <= ovf_set  | (err_ovf_q  & ~bus.err_clr);
      err_part_q    <= part_set | (err_part_q & ~bus.err_clr);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_12mhz),
    .rst_ni   (rst_n),
    .wr_vld_i (push),
    .wr_dat_i ({dc_s, byte_dat}),
    .rd_rdy_i (bus.rx_ready),
    .rd_dat_o (fifo_rd_dat),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign bus.rx_valid     = ~fifo_empty;
  assign bus.rx_dc        = fifo_rd_dat[ENTRY_W-1];
  assign bus.rx_data      = fifo_rd_dat[BYTE_W-1:0];
  assign bus.frame_start  = frame_start_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_partial  = err_part_q;

`ifdef SPI_LCD_RX_MISO_EN
  logic              sck_fall;
  logic [BYTE_W-1:0] last_q, miso_sr_q;

  assign sck_fall = ~sck_q[1] & sck_q[2];

  // Echo shifter: reload on byte completion or frame start, shift on SCK
  // falls inside a byte (the fall right after a reload keeps the new MSB).
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= '0;
      miso_sr_q <= '0;
    end else if (push) begin
      last_q    <= byte_dat;
      miso_sr_q <= byte_dat;
    end else if (frame_start_d) begin
      miso_sr_q <= last_q;
    end else if (state_q == SHIFT && sck_fall && bit_cnt_q != '0) begin
      miso_sr_q <= {miso_sr_q[BYTE_W-2:0], 1'b0};
    end
  end

  assign bus.spi_miso = miso_sr_q[BYTE_W-1];
`else
  assign bus.spi_miso = 1'b0;
`endif

endmodule
